// File: rtl/hqm_aw_cfg_target_sequencer.sv
// hqm_aw_cfg_target_sequencer
// Turns a valid/ready config request stream into single-target
// cfg_write/cfg_read strobes with a shared offset/wdata bus. It collects the
// selected target's ack/err/rdata and returns one registered response.
// Only one request is in flight at a time.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready depends only on the FSM state and rst_prep. A
// response holds rsp_valid/rsp_err/rsp_rdata stable until rsp_ready.
//
// Optional build macro HQM_AW_CFG_TGT_SEQ_TIMEOUT_EN: it adds an ack-wait
// counter. The access then ends with an error after TIMEOUT strobe cycles
// without an ack. Without the macro, ACCESS waits for the ack indefinitely.
module hqm_aw_cfg_target_sequencer #(
   parameter int NUM_TGT   = 4,
   parameter int OFFSET_W  = 8,
   parameter int DEPTH_MAX = 256,
   parameter int TIMEOUT   = 16,
   parameter int TGT_W     = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    rst_prep,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [TGT_W-1:0]        req_tgt,
   input  logic [OFFSET_W-1:0]     req_offset,
   input  logic [31:0]             req_wdata,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic                    rsp_err,
   output logic [31:0]             rsp_rdata,
   output logic [NUM_TGT-1:0]      tgt_cfg_write,
   output logic [NUM_TGT-1:0]      tgt_cfg_read,
   output logic [OFFSET_W-1:0]     tgt_cfg_offset,
   output logic [31:0]             tgt_cfg_wdata,
   input  logic [NUM_TGT-1:0]      tgt_cfg_ack,
   input  logic [NUM_TGT-1:0]      tgt_cfg_err,
   input  logic [NUM_TGT*32-1:0]   tgt_cfg_rdata,
   output logic                    busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                state_q, state_d;

   logic                  cap_write_q, cap_write_d;
   logic [TGT_W-1:0]      cap_tgt_q, cap_tgt_d;
   logic [OFFSET_W-1:0]   cap_offset_q, cap_offset_d;
   logic [31:0]           cap_wdata_q, cap_wdata_d;
   logic                  rsp_err_q, rsp_err_d;
   logic [31:0]           rsp_rdata_q, rsp_rdata_d;

   logic                  accept;
   logic                  req_in_range;
   logic [NUM_TGT-1:0]    tgt_onehot;
   logic                  sel_ack;
   logic                  sel_err;
   logic [31:0]           sel_rdata;
   logic                  tmo_expired;

   assign req_ready = (state_q == IDLE) & ~rst_prep;
   assign accept    = req_valid & req_ready;

   // Out-of-range targets or offsets are answered with an error and never
   // reach the target bus. The compare is done at 32 bits so that DEPTH_MAX
   // may exceed the offset range.
   assign req_in_range = (32'(req_tgt) < NUM_TGT) && (32'(req_offset) < DEPTH_MAX);

   // Decode the captured target into a one-hot mask and mux its ack/err/rdata.
   always_comb begin
      tgt_onehot = '0;
      sel_ack    = 1'b0;
      sel_err    = 1'b0;
      sel_rdata  = '0;
      for (int i = 0; i < NUM_TGT; i++) begin
         if (cap_tgt_q == TGT_W'(i)) begin
            tgt_onehot[i] = 1'b1;
            sel_ack       = tgt_cfg_ack[i];
            sel_err       = tgt_cfg_err[i];
            sel_rdata     = tgt_cfg_rdata[i*32 +: 32];
         end
      end
   end

`ifdef HQM_AW_CFG_TGT_SEQ_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] tmo_cnt_q;

   assign tmo_expired = (tmo_cnt_q == CNT_W'(TIMEOUT - 1));

   // Ack-wait counter: zero outside ACCESS (so it is clear on entry), and it
   // counts each ACCESS cycle that passes without an ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q <= '0;
      end else if (state_q != ACCESS) begin
         tmo_cnt_q <= '0;
      end else if (!sel_ack) begin
         tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
   end
`else
   assign tmo_expired = 1'b0;
`endif

   // FSM next state plus capture of the request and response registers.
   always_comb begin
      state_d      = state_q;
      cap_write_d  = cap_write_q;
      cap_tgt_d    = cap_tgt_q;
      cap_offset_d = cap_offset_q;
      cap_wdata_d  = cap_wdata_q;
      rsp_err_d    = rsp_err_q;
      rsp_rdata_d  = rsp_rdata_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               cap_write_d  = req_write;
               cap_tgt_d    = req_tgt;
               cap_offset_d = req_offset;
               cap_wdata_d  = req_wdata;
               if (req_in_range) begin
                  state_d = ACCESS;
               end else begin
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
                  state_d     = RESP;
               end
            end
         end
         ACCESS: begin
            // An ack in the expiry cycle takes priority over the timeout.
            if (sel_ack) begin
               rsp_err_d   = sel_err;
               rsp_rdata_d = cap_write_q ? 32'h0 : sel_rdata;
               state_d     = RESP;
            end else if (tmo_expired) begin
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and captured registers; async reset clears everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cap_write_q  <= 1'b0;
         cap_tgt_q    <= '0;
         cap_offset_q <= '0;
         cap_wdata_q  <= '0;
         rsp_err_q    <= 1'b0;
         rsp_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         cap_write_q  <= cap_write_d;
         cap_tgt_q    <= cap_tgt_d;
         cap_offset_q <= cap_offset_d;
         cap_wdata_q  <= cap_wdata_d;
         rsp_err_q    <= rsp_err_d;
         rsp_rdata_q  <= rsp_rdata_d;
      end
   end

   // Strobes decode only registered state. They therefore fall as soon as
   // ACCESS is left, or as soon as reset is asserted.
   assign tgt_cfg_write  = ((state_q == ACCESS) &&  cap_write_q) ? tgt_onehot : '0;
   assign tgt_cfg_read   = ((state_q == ACCESS) && !cap_write_q) ? tgt_onehot : '0;
   assign tgt_cfg_offset = cap_offset_q;
   assign tgt_cfg_wdata  = cap_wdata_q;

   assign rsp_valid = (state_q == RESP);
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_hqm_aw_cfg_target_sequencer.sv
// Bench for hqm_aw_cfg_target_sequencer (NUM_TGT=3, OFFSET_W=9, DEPTH_MAX=256).
// The timeout cases run only when HQM_AW_CFG_TGT_SEQ_TIMEOUT_EN is defined.
module tb_hqm_aw_cfg_target_sequencer;
  localparam int NT = 3;

  typedef struct packed {
    logic [NT-1:0] w;
    logic [NT-1:0] r;
    logic [8:0]    off;
    logic [31:0]   wd;
    logic [31:0]   len;
  } stb_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rst_prep = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_write = 1'b0;
  logic [1:0]      req_tgt = '0;
  logic [8:0]      req_offset = '0;
  logic [31:0]     req_wdata = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic            rsp_err;
  logic [31:0]     rsp_rdata;
  logic [NT-1:0]   tgt_cfg_write, tgt_cfg_read, tgt_cfg_ack, tgt_cfg_err;
  logic [8:0]      tgt_cfg_offset;
  logic [31:0]     tgt_cfg_wdata;
  logic [NT*32-1:0] tgt_cfg_rdata;
  logic            busy;

  // target model controls
  logic            ack_en = 1'b1;
  int              ack_delay = 0;
  int              strb_cnt = 0;
  logic [NT-1:0]   noise_ack = '0;
  logic [NT-1:0]   terr = '0;
  logic [31:0]     tdata [NT];

  logic [32:0]     exp_q[$];
  stb_t            stb_q[$];
  int              errors = 0;
  int              checks = 0;

  hqm_aw_cfg_target_sequencer #(
    .NUM_TGT(NT), .OFFSET_W(9), .DEPTH_MAX(256), .TIMEOUT(16), .TGT_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rst_prep(rst_prep),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_tgt(req_tgt), .req_offset(req_offset), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .tgt_cfg_write(tgt_cfg_write),
    .tgt_cfg_read(tgt_cfg_read), .tgt_cfg_offset(tgt_cfg_offset),
    .tgt_cfg_wdata(tgt_cfg_wdata), .tgt_cfg_ack(tgt_cfg_ack),
    .tgt_cfg_err(tgt_cfg_err), .tgt_cfg_rdata(tgt_cfg_rdata), .busy(busy)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // target model: ack once the strobe has been high for ack_delay cycles
  always @(posedge clk) begin
    if ((tgt_cfg_write | tgt_cfg_read) != '0) strb_cnt <= strb_cnt + 1;
    else strb_cnt <= 0;
  end

  always_comb begin
    tgt_cfg_rdata = '0;
    for (int i = 0; i < NT; i++) begin
      tgt_cfg_ack[i] = ((tgt_cfg_write[i] | tgt_cfg_read[i]) & ack_en & (strb_cnt >= ack_delay)) | noise_ack[i];
      tgt_cfg_rdata[i*32 +: 32] = tdata[i];
    end
    tgt_cfg_err = terr;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // response monitor / scoreboard
  logic        held_v = 1'b0;
  logic        held_e;
  logic [31:0] held_d;
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (held_v) begin
        chk("rsp_err_stable", 64'(rsp_err), 64'(held_e));
        chk("rsp_rdata_stable", 64'(rsp_rdata), 64'(held_d));
      end
      if (rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("rsp_err", 64'(rsp_err), 64'(e[32]));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
        end
        held_v = 1'b0;
      end else begin
        held_v = 1'b1;
        held_e = rsp_err;
        held_d = rsp_rdata;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  // strobe monitor: records each strobe burst and compares it on the fall
  logic  stb_act = 1'b0;
  stb_t  obs;
  always @(negedge clk) begin
    if ((tgt_cfg_write | tgt_cfg_read) != '0) begin
      if (!stb_act) begin
        stb_act = 1'b1;
        obs.w = tgt_cfg_write; obs.r = tgt_cfg_read;
        obs.off = tgt_cfg_offset; obs.wd = tgt_cfg_wdata; obs.len = 1;
        chk("strobe_onehot", 64'($onehot(tgt_cfg_write | tgt_cfg_read) && ((tgt_cfg_write & tgt_cfg_read) == '0)), 64'd1);
      end else begin
        obs.len = obs.len + 1;
        chk("strobe_stable", {tgt_cfg_write, tgt_cfg_read, tgt_cfg_offset, tgt_cfg_wdata},
            {obs.w, obs.r, obs.off, obs.wd});
      end
    end else if (stb_act) begin
      stb_act = 1'b0;
      if (stb_q.size() == 0) begin
        chk("strobe_unexpected", 64'(obs.w | obs.r), 64'd0);
      end else begin
        stb_t e;
        e = stb_q.pop_front();
        chk("strobe_mask", {obs.w, obs.r}, {e.w, e.r});
        chk("strobe_offset", 64'(obs.off), 64'(e.off));
        chk("strobe_wdata", 64'(obs.wd), 64'(e.wd));
        chk("strobe_len", 64'(obs.len), 64'(e.len));
      end
    end
  end

  task automatic push_exp(input logic w, input logic [1:0] t, input logic [8:0] o,
                          input logic [31:0] d, input logic e_err, input logic [31:0] e_rd,
                          input int e_len, input logic push_rsp);
    stb_t s;
    logic [NT-1:0] m;
    if (push_rsp) exp_q.push_back({e_err, e_rd});
    if (e_len > 0) begin
      m = 3'b001 << t;
      s.w = w ? m : '0;
      s.r = w ? '0 : m;
      s.off = o; s.wd = d; s.len = 32'(e_len);
      stb_q.push_back(s);
    end
  endtask

  // driver: present request, wait (bounded) for accept; leaves at posedge+1
  task automatic send(input logic w, input logic [1:0] t, input logic [8:0] o,
                      input logic [31:0] d, input logic e_err, input logic [31:0] e_rd,
                      input int e_len);
    logic acc;
    push_exp(w, t, o, d, e_err, e_rd, e_len, 1'b1);
    req_valid = 1'b1; req_write = w; req_tgt = t; req_offset = o; req_wdata = d;
    acc = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (req_ready) begin acc = 1'b1; break; end
    end
    if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!busy) begin done = 1'b1; break; end
    end
    if (!done) chk("idle_timeout", 64'(done), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < NT; i++) tdata[i] = '0;
    // reset values
    #12;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_strobes", {tgt_cfg_write, tgt_cfg_read}, 64'd0);
    chk("rst_rsp", {rsp_err, rsp_rdata}, 64'd0);
    chk("rst_bus", {tgt_cfg_offset, tgt_cfg_wdata}, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // 1: read tgt1 off3, zero-wait target, check latency
    tdata[1] = 32'h0000_00A5; ack_delay = 0;
    send(1'b0, 2'd1, 9'd3, 32'h0, 1'b0, 32'h0000_00A5, 1);
    @(negedge clk);
    chk("lat_strobe_t1", {tgt_cfg_read, 1'b0, rsp_valid}, {3'b010, 1'b0, 1'b0});
    @(negedge clk);
    chk("lat_rsp_t2", {tgt_cfg_read, 1'b0, rsp_valid}, {3'b000, 1'b0, 1'b1});
    wait_idle();

    // ack outside ACCESS is ignored
    noise_ack = 3'b111; terr = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_noise_busy", {busy, rsp_valid}, 64'd0);
    noise_ack = '0; terr = '0;

    // 2: write tgt2 off5, ack after 3 waits, noise ack/err on tgt0
    tdata[2] = 32'hCAFE_0002; ack_delay = 3; noise_ack = 3'b001; terr = 3'b001;
    send(1'b1, 2'd2, 9'd5, 32'h1234_5678, 1'b0, 32'h0, 4);
    wait_idle();
    noise_ack = '0; terr = '0;

    // 3: write with target error
    ack_delay = 0; terr = 3'b001;
    send(1'b1, 2'd0, 9'd17, 32'hA5A5_0000, 1'b1, 32'h0, 1);
    wait_idle();
    terr = '0;

    // 4: rejects (bad target, bad offset) never strobe
    send(1'b0, 2'd3, 9'd1, 32'h0, 1'b1, 32'h0, 0);
    wait_idle();
    send(1'b1, 2'd1, 9'd300, 32'hFFFF_FFFF, 1'b1, 32'h0, 0);
    wait_idle();
    send(1'b0, 2'd2, 9'd255, 32'h0, 1'b0, 32'hCAFE_0002, 1);
    wait_idle();

    // 5: response backpressure with a new request waiting
    tdata[0] = 32'h0BAD_F00D; ack_delay = 1; rsp_ready = 1'b0;
    send(1'b0, 2'd0, 9'd9, 32'h0, 1'b0, 32'h0BAD_F00D, 2);
    push_exp(1'b0, 2'd1, 9'd4, 32'h0, 1'b0, 32'h0000_00A5, 2, 1'b1);
    req_valid = 1'b1; req_write = 1'b0; req_tgt = 2'd1; req_offset = 9'd4; req_wdata = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(negedge clk);
    chk("hs_cycle_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("post_hs_req_ready", {req_ready, rsp_valid}, {1'b1, 1'b0});
    @(posedge clk); #1; req_valid = 1'b0;
    wait_idle();

    // 6: rst_prep blocks acceptance in IDLE
    rst_prep = 1'b1; req_valid = 1'b1; req_tgt = 2'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("prep_req_ready", {req_ready, busy}, 64'd0);
    end
    @(posedge clk); #1; req_valid = 1'b0; rst_prep = 1'b0;

    // rst_prep during ACCESS lets the request complete
    tdata[2] = 32'h0000_0077; ack_delay = 4;
    send(1'b0, 2'd2, 9'd8, 32'h0, 1'b0, 32'h0000_0077, 5);
    rst_prep = 1'b1;
    wait_idle();
    @(negedge clk);
    chk("prep_after_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1; rst_prep = 1'b0;

    // 7: reset in the middle of ACCESS
    ack_en = 1'b0;
    push_exp(1'b1, 2'd1, 9'd2, 32'h5555_AAAA, 1'b0, 32'h0, 3, 1'b0);
    req_valid = 1'b1; req_write = 1'b1; req_tgt = 2'd1; req_offset = 9'd2; req_wdata = 32'h5555_AAAA;
    @(negedge clk);
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1; rst_n = 1'b0;
    #1;
    chk("async_rst_drop", {tgt_cfg_write, tgt_cfg_read, busy}, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1; ack_en = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {busy, rsp_valid, req_ready}, {1'b0, 1'b0, 1'b1});
    @(posedge clk); #1;

`ifdef HQM_AW_CFG_TGT_SEQ_TIMEOUT_EN
    // 8: timeout with a dead target, then ack on the last allowed cycle
    ack_en = 1'b0; tdata[1] = 32'h0000_005A;
    send(1'b0, 2'd1, 9'd6, 32'h0, 1'b1, 32'h0, 16);
    wait_idle();
    ack_en = 1'b1; ack_delay = 15;
    send(1'b0, 2'd1, 9'd6, 32'h0, 1'b0, 32'h0000_005A, 16);
    wait_idle();
`endif

    // drain scoreboards
    for (int n = 0; n < 100 && (exp_q.size() != 0 || stb_q.size() != 0); n++) @(negedge clk);
    chk("drain_rsp_q", 64'(exp_q.size()), 64'd0);
    chk("drain_stb_q", 64'(stb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
